// File: rtl/ysyx_bus_pkg.sv
// Shared types and AXI constants for the IFU/LSU request scheduler.
package ysyx_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_B    = 3'd4
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [3:0] ID_IFU     = 4'd0;
    localparam logic [3:0] ID_LSU     = 4'd1;
    localparam logic [2:0] SIZE_BYTE  = 3'd0;
    localparam logic [2:0] SIZE_HALF  = 3'd1;
    localparam logic [2:0] SIZE_WORD  = 3'd2;

endpackage

// File: rtl/ysyx_axi_lane.sv
// Combinational 32<->64 bit lane steering between a requester and the AXI data bus.
module ysyx_axi_lane
    import ysyx_bus_pkg::*;
(
    input  logic [2:0]  addr_lo,
    input  logic [63:0] rdata_wide,
    output logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [63:0] wdata_wide,
    output logic [7:0]  wstrb_wide,
    output logic [2:0]  awsize
);

    logic [3:0] strb_shift_s;

    // Lane select for reads, replication and strobe placement for writes
    always_comb begin
        rdata        = addr_lo[2] ? rdata_wide[63:32] : rdata_wide[31:0];
        wdata_wide   = {wdata, wdata};
        strb_shift_s = wstrb << addr_lo[1:0];
        wstrb_wide   = addr_lo[2] ? {strb_shift_s, 4'b0000} : {4'b0000, strb_shift_s};
        case (wstrb)
            4'h1:    awsize = SIZE_BYTE;
            4'h3:    awsize = SIZE_HALF;
            4'hF:    awsize = SIZE_WORD;
            default: awsize = SIZE_WORD;
        endcase
    end

endmodule

// File: rtl/ysyx_axi_req_sched_chk.sv
// Simulation checks on the slave side: responses only arrive while the scheduler waits for them.
module ysyx_axi_req_sched_chk (
    input logic clk,
    input logic rst,
    input logic r_phase,
    input logic b_phase,
    input logic m_rvalid,
    input logic m_bvalid
);

    a_rvalid_in_r : assert property (@(posedge clk) disable iff (rst) m_rvalid |-> r_phase);
    a_bvalid_in_b : assert property (@(posedge clk) disable iff (rst) m_bvalid |-> b_phase);

endmodule

// File: rtl/ysyx_axi_req_sched.sv
// Serialises IFU fetches, LSU loads and LSU stores onto one 64-bit AXI4 master port,
// one transaction at a time, store > load > fetch with a starvation guard for the IFU.
module ysyx_axi_req_sched
    import ysyx_bus_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic              ifu_arready_o,
    output logic [DATA_W-1:0] ifu_rdata_o,
    output logic              ifu_rvalid_o,
    output logic              ifu_rerr_o,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic [2:0]        lsu_arsize,
    input  logic              lsu_arvalid,
    output logic              lsu_arready_o,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic              lsu_rvalid_o,
    output logic              lsu_rerr_o,
    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [3:0]        lsu_wstrb,
    input  logic              lsu_awvalid,
    output logic              lsu_awready_o,
    output logic              lsu_bvalid_o,
    output logic              lsu_berr_o,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [2:0]        m_arsize,
    output logic [3:0]        m_arid,
    output logic [7:0]        m_arlen,
    output logic [1:0]        m_arburst,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [63:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [2:0]        m_awsize,
    output logic [3:0]        m_awid,
    output logic [7:0]        m_awlen,
    output logic [1:0]        m_awburst,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [63:0]       m_wdata,
    output logic [7:0]        m_wstrb,
    output logic              m_wlast,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    state_t              state_r, state_next_s;
    owner_t              owner_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [2:0]          size_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [3:0]          wstrb_r;
    logic [STARVE_W-1:0] starve_r;
    logic                aw_done_r, w_done_r;
    logic                grant_ifu_s, grant_load_s, grant_store_s;
    logic                aw_hs_s, w_hs_s, r_done_s, b_done_s;
    logic [31:0]         lane_rdata_s;
    logic [63:0]         lane_wdata_s;
    logic [7:0]          lane_wstrb_s;
    logic [2:0]          lane_awsize_s;

    ysyx_axi_lane u_lane (
        .addr_lo    (addr_r[2:0]),
        .rdata_wide (m_rdata),
        .rdata      (lane_rdata_s),
        .wdata      (wdata_r),
        .wstrb      (wstrb_r),
        .wdata_wide (lane_wdata_s),
        .wstrb_wide (lane_wstrb_s),
        .awsize     (lane_awsize_s)
    );

    ysyx_axi_req_sched_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .r_phase  (state_r == ST_R),
        .b_phase  (state_r == ST_B),
        .m_rvalid (m_rvalid),
        .m_bvalid (m_bvalid)
    );

    assign aw_hs_s  = m_awvalid & m_awready;
    assign w_hs_s   = m_wvalid & m_wready;
    assign r_done_s = m_rready & m_rvalid & m_rlast;
    assign b_done_s = m_bready & m_bvalid;

    // Arbitration in IDLE; a starved IFU overrides the fixed priority
    always_comb begin
        grant_ifu_s   = 1'b0;
        grant_load_s  = 1'b0;
        grant_store_s = 1'b0;
        if (state_r == ST_IDLE && !rst) begin
            if (starve_r == STARVE_LIM && ifu_arvalid) grant_ifu_s = 1'b1;
            else if (lsu_awvalid) grant_store_s = 1'b1;
            else if (lsu_arvalid) grant_load_s = 1'b1;
            else if (ifu_arvalid) grant_ifu_s = 1'b1;
            else grant_ifu_s = 1'b0;
        end else begin
            grant_ifu_s = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_next_s;
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_store_s) state_next_s = ST_AW;
                else if (grant_load_s || grant_ifu_s) state_next_s = ST_AR;
                else state_next_s = ST_IDLE;
            end
            ST_AR:   state_next_s = m_arready ? ST_R : ST_AR;
            ST_R:    state_next_s = (m_rvalid && m_rlast) ? ST_IDLE : ST_R;
            ST_AW:   state_next_s = ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) ? ST_B : ST_AW;
            ST_B:    state_next_s = m_bvalid ? ST_IDLE : ST_B;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // AXI channel outputs decoded from the state and latched request
    always_comb begin
        ifu_arready_o = grant_ifu_s;
        lsu_arready_o = grant_load_s;
        lsu_awready_o = grant_store_s;
        m_arvalid     = !rst && (state_r == ST_AR);
        m_araddr      = addr_r;
        m_arsize      = (owner_r == OWN_IFU) ? SIZE_WORD : size_r;
        m_arid        = (owner_r == OWN_IFU) ? ID_IFU : ID_LSU;
        m_arlen       = 8'd0;
        m_arburst     = BURST_INCR;
        m_rready      = !rst && (state_r == ST_R);
        m_awvalid     = !rst && (state_r == ST_AW) && !aw_done_r;
        m_awaddr      = addr_r;
        m_awsize      = lane_awsize_s;
        m_awid        = ID_LSU;
        m_awlen       = 8'd0;
        m_awburst     = BURST_INCR;
        m_wvalid      = !rst && (state_r == ST_AW) && !w_done_r;
        m_wlast       = m_wvalid;
        m_wdata       = lane_wdata_s;
        m_wstrb       = lane_wstrb_s;
        m_bready      = !rst && (state_r == ST_B);
    end

    // Request latch, starvation counter and write-handshake tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r   <= OWN_IFU;
            addr_r    <= {ADDR_W{1'b0}};
            size_r    <= 3'd0;
            wdata_r   <= {DATA_W{1'b0}};
            wstrb_r   <= 4'd0;
            starve_r  <= {STARVE_W{1'b0}};
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            if (grant_ifu_s || grant_load_s || grant_store_s) begin
                owner_r <= grant_ifu_s ? OWN_IFU : OWN_LSU;
                addr_r  <= grant_store_s ? lsu_awaddr : (grant_load_s ? lsu_araddr : ifu_araddr);
                size_r  <= grant_load_s ? lsu_arsize : SIZE_WORD;
                wdata_r <= lsu_wdata;
                wstrb_r <= lsu_wstrb;
            end
            if (state_r == ST_IDLE) begin
                if (grant_ifu_s || !ifu_arvalid) starve_r <= {STARVE_W{1'b0}};
                else if ((grant_load_s || grant_store_s) && starve_r != STARVE_LIM)
                    starve_r <= starve_r + 1'b1;
            end
            if (state_r == ST_AW) begin
                if (aw_hs_s) aw_done_r <= 1'b1;
                if (w_hs_s)  w_done_r  <= 1'b1;
            end else begin
                aw_done_r <= 1'b0;
                w_done_r  <= 1'b0;
            end
        end
    end

    // Registered completion pulses and response data back to the requesters
    always_ff @(posedge clk) begin
        if (rst) begin
            ifu_rvalid_o <= 1'b0;
            ifu_rdata_o  <= {DATA_W{1'b0}};
            ifu_rerr_o   <= 1'b0;
            lsu_rvalid_o <= 1'b0;
            lsu_rdata_o  <= {DATA_W{1'b0}};
            lsu_rerr_o   <= 1'b0;
            lsu_bvalid_o <= 1'b0;
            lsu_berr_o   <= 1'b0;
        end else begin
            ifu_rvalid_o <= r_done_s && (owner_r == OWN_IFU);
            lsu_rvalid_o <= r_done_s && (owner_r == OWN_LSU);
            lsu_bvalid_o <= b_done_s;
            if (r_done_s && owner_r == OWN_IFU) begin
                ifu_rdata_o <= lane_rdata_s;
                ifu_rerr_o  <= (m_rresp != RESP_OKAY);
            end
            if (r_done_s && owner_r == OWN_LSU) begin
                lsu_rdata_o <= lane_rdata_s;
                lsu_rerr_o  <= (m_rresp != RESP_OKAY);
            end
            if (b_done_s) lsu_berr_o <= (m_bresp != RESP_OKAY);
        end
    end

endmodule
